tick_period_monitor: RTL
========================

Name: tick_period_monitor

Overview:
- Receive-side checker for the periodic single-cycle strobe produced by the team's slow-tick generator.
- Detects rising edges of the strobe and measures the number of clock cycles between successive ticks.
- Declares lock after a run of in-tolerance periods, and flags short or missing ticks while locked.
- Sits beside every consumer of the slow tick, so compute stages can gate on a verified tick rate.

Parameters:
- PERIOD, 28, expected cycles between ticks (tick-to-tick distance).
- TOL, 0, allowed deviation in cycles; a period is good when PERIOD-TOL <= period <= PERIOD+TOL.
- LOCK_COUNT, 4, consecutive good periods required to assert lock.
- CNT_W, 8, cycle-counter width; PERIOD+TOL+1 must be < 2^CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick_in  in  1  strobe from the tick generator; sampled every clk.
- period_out  out  CNT_W  last measured tick-to-tick period.
- period_valid  out  1  one-cycle pulse when period_out updates.
- locked  out  1  high while the tick rate is verified.
- err_short  out  1  one-cycle pulse: tick arrived early while locked.
- err_missing  out  1  one-cycle pulse: tick late or absent while locked.
- err_count  out  16  total error pulses, saturating.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0, cycle counter 0, good-run counter 0, state IDLE. Reset asserted mid-operation aborts everything identically.
- Tick event: a cycle where tick_in=1 and the registered previous tick_in=0. A level held high for N cycles is one tick. The edge register clears to 0 on reset.
- Cycle counter cnt:
  - On a tick cycle, cnt<=1.
  - Otherwise cnt<=cnt+1, saturating at 2^CNT_W-1.
  - At a tick, cnt equals the cycles since the previous tick (ticks at cycles 0 and 28 give 28).
- Measurement: on every tick except the first after reset, period_out<=cnt and period_valid=1 on the following cycle (latency 1). period_out holds between updates.
- FSM states: IDLE, ACQUIRE, LOCKED.
- IDLE:
  - First tick goes to ACQUIRE, good_cnt=0.
  - No measurement is made.
- ACQUIRE:
  - Good period: good_cnt+1; when the new value equals LOCK_COUNT, go to LOCKED.
  - Bad period: good_cnt=0, stay in ACQUIRE.
  - Timeout: good_cnt=0, no error pulse.
- LOCKED:
  - Good period: stay in LOCKED.
  - Short period (cnt < PERIOD-TOL): err_short pulse, go to ACQUIRE, good_cnt=0.
  - Long period (cnt > PERIOD+TOL): err_missing pulse, go to ACQUIRE, good_cnt=0.
- Timeout: no tick this cycle and cnt == PERIOD+TOL+1.
  - In LOCKED: err_missing pulse, go to ACQUIRE, good_cnt=0.
  - The late tick that follows is judged in ACQUIRE, so no second error is raised.
- Simultaneous tick and timeout threshold: the tick wins. The period is measured as PERIOD+TOL+1 (long); exactly one err_missing is raised if in LOCKED.
- Output timing:
  - locked is a registered decode of state==LOCKED; it asserts the cycle after the LOCK_COUNT-th good tick.
  - Error pulses are registered, 1 cycle after the causing event, and coincide with period_valid for tick-caused errors.
- err_count increments by 1 on each err_short or err_missing pulse; it holds at 16'hFFFF.

Test Plan:
- Defaults, tick every 28 cycles, 6 ticks -> first period_valid after tick 2 with period_out=28; locked=1 one cycle after tick 5; no errors.
- Locked, next tick after 20 cycles -> period_out=20, err_short pulse, locked=0, err_count=1; four further 28-cycle periods -> locked=1 again.
- Locked, tick withheld -> err_missing pulse when cnt reaches 29, locked=0, err_count=1; tick at 40 cycles -> period_out=40 with no additional error.
- tick_in held high 5 cycles every 28-cycle interval -> treated as single ticks, period_out=28, lock reached normally.
- rst pulsed while locked -> all outputs 0 the next cycle; next tick produces no period_valid; the one after gives period_out=28.
- TOL=1: periods 27, 29, 28, 27 -> lock; a period of 30 -> err_missing; a period of 26 while locked -> err_short.

Source files
------------

// File: rtl/tick_period_monitor_if.sv
// Tick strobe in, period measurement and lock/error status out.
// The monitor sits on the slave side; the tick source and consumers use the master side.
interface tick_period_monitor_if #(
  parameter int CNT_W = 8
);
  logic             tick_in;
  logic [CNT_W-1:0] period_out;
  logic             period_valid;
  logic             locked;
  logic             err_short;
  logic             err_missing;
  logic [15:0]      err_count;

  modport master (
    output tick_in,
    input  period_out, period_valid, locked, err_short, err_missing, err_count
  );

  modport slave (
    input  tick_in,
    output period_out, period_valid, locked, err_short, err_missing, err_count
  );
endinterface

// File: rtl/tick_period_monitor.sv
// Measures tick-to-tick distance of a slow strobe, locks after LOCK_COUNT good periods.
// All outputs are registered: period/error results appear one cycle after the tick edge.
module tick_period_monitor #(
  parameter int PERIOD     = 28,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  rst,
  tick_period_monitor_if.slave bus
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO      = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [GW-1:0]    LOCK_N  = GW'(LOCK_COUNT);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [GW-1:0]    good_cnt, good_nxt, good_inc;
  logic [CNT_W-1:0] cnt;
  logic             tick_prev;
  logic             tick;
  logic             good, short_p, long_p, timeout;
  logic             meas, short_nxt, missing_nxt;

  assign tick     = bus.tick_in & ~tick_prev;
  assign short_p  = cnt < LO;
  assign long_p   = cnt > HI;
  assign good     = ~short_p & ~long_p;
  // A tick landing exactly on the threshold is measured as a long period instead.
  assign timeout  = ~tick && (cnt == TMO);
  assign good_inc = good_cnt + 1'b1;

  always_comb begin
    state_nxt   = state;
    good_nxt    = good_cnt;
    meas        = 1'b0;
    short_nxt   = 1'b0;
    missing_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = ACQUIRE;
          good_nxt  = '0;
        end
      end
      ACQUIRE: begin
        if (tick) begin
          meas = 1'b1;
          if (good) begin
            good_nxt = good_inc;
            if (good_inc == LOCK_N) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end else if (timeout) begin
          good_nxt = '0;
        end
      end
      LOCKED: begin
        if (tick) begin
          meas = 1'b1;
          if (short_p) begin
            short_nxt = 1'b1;
            state_nxt = ACQUIRE;
            good_nxt  = '0;
          end else if (long_p) begin
            missing_nxt = 1'b1;
            state_nxt   = ACQUIRE;
            good_nxt    = '0;
          end
        end else if (timeout) begin
          missing_nxt = 1'b1;
          state_nxt   = ACQUIRE;
          good_nxt    = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        good_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      good_cnt         <= '0;
      cnt              <= '0;
      tick_prev        <= 1'b0;
      bus.period_out   <= '0;
      bus.period_valid <= 1'b0;
      bus.locked       <= 1'b0;
      bus.err_short    <= 1'b0;
      bus.err_missing  <= 1'b0;
      bus.err_count    <= '0;
    end else begin
      state            <= state_nxt;
      good_cnt         <= good_nxt;
      tick_prev        <= bus.tick_in;
      if (tick)                cnt <= CNT_W'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      bus.period_valid <= meas;
      if (meas) bus.period_out <= cnt;
      bus.locked       <= (state_nxt == LOCKED);
      bus.err_short    <= short_nxt;
      bus.err_missing  <= missing_nxt;
      if ((short_nxt | missing_nxt) && (bus.err_count != 16'hFFFF))
        bus.err_count <= bus.err_count + 16'd1;
    end
  end
endmodule
